myproject_div_seq_22s_6s_16: RTL

//  Sequential signed divider, the inverse of the 16s x 6s -> 22s product path: recovers a 16-bit operand from a 22-bit product and 6-bit factor.

---
 rtl/myproject_div_pkg.sv | 24 ++
 rtl/myproject_div_step.sv | 25 ++
 rtl/myproject_div_seq_22s_6s_16.sv | 136 +++++++++++++
 3 files changed

// File: rtl/myproject_div_pkg.sv
// Shared widths, FSM states and range constants for the sequential signed divider.
package myproject_div_pkg;

  localparam int DIVIDEND_W = 22;
  localparam int DIVISOR_W  = 6;
  localparam int QUOT_W     = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIVIDEND_W - 1);

  localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  // Largest quotient magnitudes that still fit QUOT_W signed, per sign.
  localparam logic [DIVIDEND_W-1:0] MAG_POS_LIM = DIVIDEND_W'(2**(QUOT_W-1) - 1);
  localparam logic [DIVIDEND_W-1:0] MAG_NEG_LIM = DIVIDEND_W'(2**(QUOT_W-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/myproject_div_step.sv
// One restoring division step on unsigned magnitudes.
// The partial remainder is always below the divisor magnitude, so after shifting
// in the next dividend bit the trial value needs only one extra bit.
module myproject_div_step
  import myproject_div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] prem,
  input  logic [DIVISOR_W-1:0] dvs,
  input  logic                 dbit,
  output logic [DIVISOR_W-1:0] nrem,
  output logic                 qbit
);

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;

  // Shift in the next bit and subtract the divisor when it fits.
  always_comb begin
    trial = {prem, dbit};
    diff  = trial - {1'b0, dvs};
    qbit  = (trial >= {1'b0, dvs});
    nrem  = qbit ? diff[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/myproject_div_seq_22s_6s_16.sv
// Sequential signed divider 22s / 6s -> 16s quotient, 6s remainder, C semantics.
// Optional macro MYPROJECT_DIV_SAT_EN: saturate dout on overflow instead of wrapping.
//
//  state | meaning
//  IDLE  | din_rdy=1, waiting for an operand pair
//  CALC  | one restoring step per cycle on magnitudes, MSB first
//  DONE  | result registered; dout_vld raised next cycle, held until dout_rdy
module myproject_div_seq_22s_6s_16
  import myproject_div_pkg::*;
(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [QUOT_W-1:0]     dout,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  div0,
  output logic                  ovf
);

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W-1:0]  prem;
  logic [DIVIDEND_W-2:0] quot;
  logic [CNT_W-1:0]      cnt;
  logic                  neg_q;
  logic                  neg_r;

  logic [DIVIDEND_W-1:0] mag0;
  logic [DIVISOR_W-1:0]  mag1;
  logic [DIVISOR_W-1:0]  step_rem;
  logic                  step_q;
  logic [DIVIDEND_W-1:0] uq;
  logic [DIVIDEND_W-1:0] sq;
  logic                  ovf_c;
  logic [QUOT_W-1:0]     dout_c;
  logic [DIVISOR_W-1:0]  rem_c;

  assign din_rdy = (state == IDLE);

  myproject_div_step u_step (
    .prem (prem),
    .dvs  (dvs),
    .dbit (dvd[DIVIDEND_W-1]),
    .nrem (step_rem),
    .qbit (step_q)
  );

  // Operand magnitudes and final sign fix-up / range check of the last step.
  always_comb begin
    mag0  = din0[DIVIDEND_W-1] ? -din0 : din0;
    mag1  = din1[DIVISOR_W-1]  ? -din1 : din1;
    uq    = {quot, step_q};
    sq    = neg_q ? -uq : uq;
    ovf_c = neg_q ? (uq > MAG_NEG_LIM) : (uq > MAG_POS_LIM);
`ifdef MYPROJECT_DIV_SAT_EN
    if (ovf_c) dout_c = neg_q ? QUOT_MIN : QUOT_MAX;
    else       dout_c = QUOT_W'(sq);
`else
    dout_c = QUOT_W'(sq);
`endif
    rem_c = neg_r ? -step_rem : step_rem;
  end

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      prem     <= '0;
      quot     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dout     <= '0;
      rem      <= '0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_vld) begin
            if (din1 == '0) begin
              // Division by zero bypasses the iterations entirely.
              state <= DONE;
              dout  <= din0[DIVIDEND_W-1] ? QUOT_MIN : QUOT_MAX;
              rem   <= '0;
              div0  <= 1'b1;
              ovf   <= 1'b0;
            end else begin
              state <= CALC;
              dvd   <= mag0;
              dvs   <= mag1;
              neg_q <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
              neg_r <= din0[DIVIDEND_W-1];
              prem  <= '0;
              quot  <= '0;
              cnt   <= CNT_LOAD;
            end
          end
        end
        CALC: begin
          dvd  <= dvd << 1;
          prem <= step_rem;
          quot <= uq[DIVIDEND_W-2:0];
          if (cnt == '0) begin
            state <= DONE;
            dout  <= dout_c;
            rem   <= rem_c;
            div0  <= 1'b0;
            ovf   <= ovf_c;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!dout_vld) begin
            dout_vld <= 1'b1;
          end else if (dout_rdy) begin
            dout_vld <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
